// File: rtl/load_store_unit.sv
// Load/store unit: runs one req/ack data-memory access per start, with
// lane steering for stores, load extraction/extension, and fault flags.
module load_store_unit #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        is_store_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] result_o,
    output logic        misaligned_o,
    output logic        illegal_o,
    output logic        bus_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        addr_lo_q, addr_lo_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              is_store_q, is_store_d;

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [31:0]       result_q, result_d;
    logic              mis_q, mis_d;
    logic              ill_q, ill_d;
    logic              berr_q, berr_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    logic              illegal_c;
    logic              misaligned_c;
    logic [3:0]        st_be_c;
    logic [31:0]       st_wdata_c;
    logic [31:0]       rd_shift_c;
    logic [31:0]       ld_value_c;
    logic [CNT_W-1:0]  cnt_inc_c;

    // Decode legality, alignment and store lanes from the incoming request
    always_comb begin
        illegal_c    = 1'b1;
        misaligned_c = 1'b0;
        st_be_c      = 4'b0000;
        st_wdata_c   = 32'h0;
        if (is_store_i) begin
            illegal_c = !(funct3_i inside {3'b000, 3'b001, 3'b010});
        end else begin
            illegal_c = !(funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        end
        // Illegal codes take precedence, so alignment is only judged for legal ones
        if (!illegal_c) begin
            misaligned_c = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                           ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
        end
        case (funct3_i[1:0])
            2'b00: begin
                st_be_c    = 4'(4'b0001 << addr_i[1:0]);
                st_wdata_c = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                st_be_c    = 4'(4'b0011 << addr_i[1:0]);
                st_wdata_c = {2{wdata_i[15:0]}};
            end
            default: begin
                st_be_c    = 4'b1111;
                st_wdata_c = wdata_i;
            end
        endcase
    end

    // Extract and extend the addressed byte/halfword from the read data
    always_comb begin
        rd_shift_c = mem_rdata_i >> {addr_lo_q, 3'b000};
        case (funct3_q)
            3'b000:  ld_value_c = {{24{rd_shift_c[7]}}, rd_shift_c[7:0]};
            3'b001:  ld_value_c = {{16{rd_shift_c[15]}}, rd_shift_c[15:0]};
            3'b010:  ld_value_c = rd_shift_c;
            3'b100:  ld_value_c = {24'h0, rd_shift_c[7:0]};
            3'b101:  ld_value_c = {16'h0, rd_shift_c[15:0]};
            default: ld_value_c = 32'h0;
        endcase
    end

    assign cnt_inc_c = CNT_W'(cnt_q + CNT_W'(1));

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_lo_d   = addr_lo_q;
        funct3_d    = funct3_q;
        is_store_d  = is_store_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        result_d    = 32'h0;
        mis_d       = 1'b0;
        ill_d       = 1'b0;
        berr_d      = 1'b0;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    addr_lo_d  = addr_i[1:0];
                    funct3_d   = funct3_i;
                    is_store_d = is_store_i;
                    busy_d     = 1'b1;
                    if (illegal_c || misaligned_c) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        ill_d   = illegal_c;
                        mis_d   = misaligned_c;
                    end else begin
                        state_d     = S_REQ;
                        cnt_d       = '0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = is_store_i;
                        mem_addr_d  = {addr_i[31:2], 2'b00};
                        mem_be_d    = is_store_i ? st_be_c : 4'b1111;
                        mem_wdata_d = is_store_i ? st_wdata_c : 32'h0;
                    end
                end
            end
            S_REQ: begin
                busy_d = 1'b1;
                if (mem_ack_i) begin
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                    result_d = is_store_q ? 32'h0 : ld_value_c;
                end else begin
                    cnt_d = cnt_inc_c;
                    if (cnt_inc_c == CNT_W'(ACK_TIMEOUT)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        berr_d  = 1'b1;
                    end
                end
                if (mem_ack_i || (cnt_inc_c == CNT_W'(ACK_TIMEOUT))) begin
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = 32'h0;
                    mem_be_d    = 4'b0000;
                    mem_wdata_d = 32'h0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            addr_lo_q   <= 2'b00;
            funct3_q    <= 3'b000;
            is_store_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= 32'h0;
            mis_q       <= 1'b0;
            ill_q       <= 1'b0;
            berr_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_lo_q   <= addr_lo_d;
            funct3_q    <= funct3_d;
            is_store_q  <= is_store_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            result_q    <= result_d;
            mis_q       <= mis_d;
            ill_q       <= ill_d;
            berr_q      <= berr_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign result_o     = result_q;
    assign misaligned_o = mis_q;
    assign illegal_o    = ill_q;
    assign bus_err_o    = berr_q;
    assign mem_req_o    = mem_req_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_be_o     = mem_be_q;
    assign mem_wdata_o  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with hand-computed expectations.
module tb_load_store_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        is_store_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;
    logic        misaligned_o;
    logic        illegal_o;
    logic        bus_err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    int n_vec = 0;
    int n_err = 0;

    load_store_unit #(.ACK_TIMEOUT(4)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .is_store_i   (is_store_i),
        .funct3_i     (funct3_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .result_o     (result_o),
        .misaligned_o (misaligned_o),
        .illegal_o    (illegal_o),
        .bus_err_o    (bus_err_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_be_o     (mem_be_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_ack_i    (mem_ack_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] flags();
        return {29'h0, misaligned_o, illegal_o, bus_err_o};
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_busy"},  32'(busy_o),    32'd0);
        chk({tag, "_done"},  32'(done_o),    32'd0);
        chk({tag, "_res"},   result_o,       32'h0);
        chk({tag, "_flags"}, flags(),        32'h0);
        chk({tag, "_req"},   32'(mem_req_o), 32'd0);
        chk({tag, "_mem"},   {27'h0, mem_we_o, mem_be_o} | mem_addr_o | mem_wdata_o, 32'h0);
    endtask

    // One bus access; ack arrives after 'waits' wait cycles
    task automatic run_access(input string tag, input logic st, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int waits,
                              input logic [3:0] exp_be, input logic [31:0] exp_wd,
                              input logic [31:0] exp_res);
        start_i = 1'b1; is_store_i = st; funct3_i = f3; addr_i = addr; wdata_i = wdata;
        tick();
        start_i = 1'b0;
        for (int i = 0; i <= waits; i++) begin
            chk({tag, "_req"},  32'(mem_req_o), 32'd1);
            chk({tag, "_busy"}, 32'(busy_o),    32'd1);
            chk({tag, "_done0"}, 32'(done_o),   32'd0);
            if (i == 0) begin
                chk({tag, "_we"},    32'(mem_we_o), 32'(st));
                chk({tag, "_addr"},  mem_addr_o,    {addr[31:2], 2'b00});
                chk({tag, "_be"},    32'(mem_be_o), 32'(exp_be));
                chk({tag, "_wdata"}, mem_wdata_o,   exp_wd);
            end
            if (i == waits) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = rdata;
            end
            tick();
        end
        mem_ack_i = 1'b0;
        chk({tag, "_done"},  32'(done_o),    32'd1);
        chk({tag, "_res"},   result_o,       exp_res);
        chk({tag, "_flags"}, flags(),        32'h0);
        chk({tag, "_reqlo"}, 32'(mem_req_o), 32'd0);
        tick();
        check_idle({tag, "_idle"});
    endtask

    // Access faulting at start; exp_flags = {misaligned, illegal, bus_err}
    task automatic run_fault(input string tag, input logic st, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [2:0] exp_flags);
        start_i = 1'b1; is_store_i = st; funct3_i = f3; addr_i = addr; wdata_i = 32'hFFFF_FFFF;
        tick();
        start_i = 1'b0;
        chk({tag, "_done"},  32'(done_o),    32'd1);
        chk({tag, "_busy"},  32'(busy_o),    32'd1);
        chk({tag, "_flags"}, flags(),        32'(exp_flags));
        chk({tag, "_res"},   result_o,       32'h0);
        chk({tag, "_req"},   32'(mem_req_o), 32'd0);
        tick();
        check_idle({tag, "_idle"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_cnt;
        int req_cnt;
        int req_total;
        int done_at [3];

        rst_i = 1'b1; start_i = 1'b0; is_store_i = 1'b0; funct3_i = 3'b000;
        addr_i = 32'h0; wdata_i = 32'h0; mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
        tick(); tick();
        check_idle("reset");
        rst_i = 1'b0;
        tick();

        // Loads and stores with assorted lanes
        run_access("lb",  1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80AA_BBCC, 0, 4'b1111, 32'h0, 32'hFFFF_FF80);
        run_access("lbu", 1'b0, 3'b100, 32'h0000_1003, 32'h0, 32'h80AA_BBCC, 0, 4'b1111, 32'h0, 32'h0000_0080);
        run_access("lh",  1'b0, 3'b001, 32'h0000_1002, 32'h0, 32'h80AA_BBCC, 1, 4'b1111, 32'h0, 32'hFFFF_80AA);
        run_access("lhu", 1'b0, 3'b101, 32'h0000_1000, 32'h0, 32'h80AA_BBCC, 0, 4'b1111, 32'h0, 32'h0000_BBCC);
        run_access("lw",  1'b0, 3'b010, 32'h0000_1004, 32'h0, 32'h80AA_BBCC, 2, 4'b1111, 32'h0, 32'h80AA_BBCC);
        run_access("sh",  1'b1, 3'b001, 32'h0000_2002, 32'h1234_5678, 32'hFFFF_FFFF, 0, 4'b1100, 32'h5678_5678, 32'h0);
        run_access("sb",  1'b1, 3'b000, 32'h0000_4001, 32'h0000_00A5, 32'hFFFF_FFFF, 1, 4'b0010, 32'hA5A5_A5A5, 32'h0);
        run_access("sw",  1'b1, 3'b010, 32'h0000_4000, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 0, 4'b1111, 32'hDEAD_BEEF, 32'h0);

        // Faults detected at start
        run_fault("lw_mis",   1'b0, 3'b010, 32'h0000_3001, 3'b100);
        run_fault("lh_mis",   1'b0, 3'b001, 32'h0000_3001, 3'b100);
        run_fault("ld_ill",   1'b0, 3'b011, 32'h0000_3000, 3'b010);
        run_fault("st_ill",   1'b1, 3'b100, 32'h0000_3000, 3'b010);
        run_fault("ill_mis",  1'b0, 3'b110, 32'h0000_3003, 3'b010);

        // Timeout: no ack, request held for 4 cycles
        start_i = 1'b1; is_store_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h0000_5000;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("to_req", 32'(mem_req_o), 32'd1);
            chk("to_done0", 32'(done_o), 32'd0);
            tick();
        end
        chk("to_done",  32'(done_o),    32'd1);
        chk("to_flags", flags(),        32'h1);
        chk("to_res",   result_o,       32'h0);
        chk("to_reqlo", 32'(mem_req_o), 32'd0);
        tick();
        check_idle("to_idle");

        // Ack in the expiry cycle completes normally
        run_access("to_ack", 1'b0, 3'b010, 32'h0000_5000, 32'h0, 32'h1122_3344, 3, 4'b1111, 32'h0, 32'h1122_3344);

        // start_i held high across three LW accesses, ack in third REQ cycle
        done_cnt = 0; req_cnt = 0; req_total = 0;
        start_i = 1'b1; is_store_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h0000_6000;
        mem_rdata_i = 32'hCAFE_F00D;
        for (int cyc = 0; cyc < 15; cyc++) begin
            if (done_o) begin
                if (done_cnt < 3) done_at[done_cnt] = cyc;
                done_cnt++;
                if (done_cnt == 3) start_i = 1'b0;
            end
            if (mem_req_o) begin
                req_cnt++;
                req_total++;
            end else begin
                req_cnt = 0;
            end
            mem_ack_i = mem_req_o && (req_cnt == 3);
            tick();
        end
        mem_ack_i = 1'b0;
        chk("b2b_dones", 32'(done_cnt),  32'd3);
        chk("b2b_reqs",  32'(req_total), 32'd9);
        chk("b2b_d0",    32'(done_at[0]), 32'd4);
        chk("b2b_d1",    32'(done_at[1]), 32'd9);
        chk("b2b_d2",    32'(done_at[2]), 32'd14);
        check_idle("b2b_idle");

        // Reset in the second REQ cycle, then a stray ack in IDLE
        start_i = 1'b1; is_store_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h0000_7000;
        tick();
        start_i = 1'b0;
        chk("rst_req1", 32'(mem_req_o), 32'd1);
        tick();
        chk("rst_req2", 32'(mem_req_o), 32'd1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check_idle("rst_mid");
        mem_ack_i = 1'b1; mem_rdata_i = 32'h5555_AAAA;
        tick();
        mem_ack_i = 1'b0;
        check_idle("stray_ack");
        tick();
        check_idle("stray_ack2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
